// File: rtl/mant_div_datapath.sv
// Restoring mantissa divider datapath: one quotient bit per shift cycle.
// The load/shift sequencing comes from an external divider control FSM.
// Optional feature: define MANT_DIV_STICKY_EN to register the remainder-non-zero
// sticky bit when the result becomes valid; otherwise out_sticky is tied low.
module mant_div_datapath #(
    parameter int MANT_W = 24,
    parameter int Q_W    = 26
) (
    input  logic              in_Clk,
    input  logic              in_Rst_N,
    input  logic              in_load,
    input  logic              in_shift_en,
    input  logic [MANT_W-1:0] in_dividend,
    input  logic [MANT_W-1:0] in_divisor,
    output logic [Q_W-1:0]    out_quotient,
    output logic              out_sticky,
    output logic              out_valid,
    output logic              out_busy,
    output logic [4:0]        out_count,
    output logic              out_dz,
    output logic              out_ovf
);

    logic [MANT_W:0]   rem_q, rem_d;
    logic [MANT_W-1:0] div_q, div_d;
    logic [Q_W-1:0]    q_q, q_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              prev_shift_q, prev_shift_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              dz_q, dz_d;
    logic              ovf_q, ovf_d;

    logic signed [MANT_W+1:0] trial;
    logic                     do_shift;
    logic                     finish;
    logic [4:0]               cnt_inc;

    // Saturating shift-cycle counter increment (holds at 31).
    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

    // Trial subtraction of the divisor from the partial remainder, one extra
    // sign bit so a negative result means "quotient bit is zero".
    always_comb begin
        trial = $signed({1'b0, rem_q}) - $signed({2'b00, div_q});
    end

    // Next-state for the divider registers: load wins over shift, shifts are
    // only accepted while busy, and the result is flagged the cycle after the
    // shift enable falls.
    always_comb begin
        rem_d        = rem_q;
        div_d        = div_q;
        q_d          = q_q;
        cnt_d        = cnt_q;
        prev_shift_d = prev_shift_q;
        valid_d      = 1'b0;
        busy_d       = busy_q;
        dz_d         = dz_q;
        ovf_d        = ovf_q;
        do_shift     = in_shift_en && busy_q && !in_load;
        finish       = busy_q && prev_shift_q && !in_shift_en && !in_load;
        cnt_inc      = sat_inc(cnt_q);
        if (in_load) begin
            rem_d        = {1'b0, in_dividend};
            div_d        = in_divisor;
            q_d          = '0;
            cnt_d        = '0;
            prev_shift_d = 1'b0;
            busy_d       = 1'b1;
            dz_d         = (in_divisor == '0);
            ovf_d        = 1'b0;
        end else begin
            if (do_shift) begin
                if (!trial[MANT_W+1]) begin
                    rem_d = {trial[MANT_W-1:0], 1'b0};
                    q_d   = {q_q[Q_W-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[MANT_W-1:0], 1'b0};
                    q_d   = {q_q[Q_W-2:0], 1'b0};
                end
                cnt_d = cnt_inc;
                if (int'(cnt_inc) > Q_W) begin
                    ovf_d = 1'b1;
                end
            end
            prev_shift_d = do_shift;
            if (finish) begin
                valid_d = 1'b1;
                busy_d  = 1'b0;
            end
        end
    end

    // Divider state registers with asynchronous clear.
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            rem_q        <= '0;
            div_q        <= '0;
            q_q          <= '0;
            cnt_q        <= '0;
            prev_shift_q <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            dz_q         <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            rem_q        <= rem_d;
            div_q        <= div_d;
            q_q          <= q_d;
            cnt_q        <= cnt_d;
            prev_shift_q <= prev_shift_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            dz_q         <= dz_d;
            ovf_q        <= ovf_d;
        end
    end

`ifdef MANT_DIV_STICKY_EN
    logic sticky_q, sticky_d;

    // Sticky captures remainder != 0 when the result is flagged; cleared on load.
    always_comb begin
        sticky_d = sticky_q;
        if (in_load) begin
            sticky_d = 1'b0;
        end else if (finish) begin
            sticky_d = (rem_q != '0);
        end
    end

    // Sticky register with asynchronous clear.
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign out_sticky = sticky_q;
`else
    assign out_sticky = 1'b0;
`endif

    assign out_quotient = q_q;
    assign out_count    = cnt_q;
    assign out_valid    = valid_q;
    assign out_busy     = busy_q;
    assign out_dz       = dz_q;
    assign out_ovf      = ovf_q;

endmodule

// File: tb/tb_mant_div_datapath.sv
// Directed self-checking bench for mant_div_datapath (default parameters).
module tb_mant_div_datapath;

`ifdef MANT_DIV_STICKY_EN
    localparam logic STICKY_ON = 1'b1;
`else
    localparam logic STICKY_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        load;
    logic        shift_en;
    logic [23:0] dividend;
    logic [23:0] divisor;
    logic [25:0] quotient;
    logic        sticky;
    logic        valid;
    logic        busy;
    logic [4:0]  count;
    logic        dz;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    mant_div_datapath #(.MANT_W(24), .Q_W(26)) dut (
        .in_Clk      (clk),
        .in_Rst_N    (rst_n),
        .in_load     (load),
        .in_shift_en (shift_en),
        .in_dividend (dividend),
        .in_divisor  (divisor),
        .out_quotient(quotient),
        .out_sticky  (sticky),
        .out_valid   (valid),
        .out_busy    (busy),
        .out_count   (count),
        .out_dz      (dz),
        .out_ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load operands (optionally with shift_en already high), run n shifts,
    // drop shift_en and step to the valid cycle.
    task automatic run_div(input string tag, input logic [23:0] a, input logic [23:0] b,
                           input int n, input logic overlap);
        dividend = a;
        divisor  = b;
        load     = 1'b1;
        shift_en = overlap;
        tick();
        load = 1'b0;
        chk({tag, "_busy_after_load"}, {31'b0, busy}, 32'd1);
        chk({tag, "_count_after_load"}, {27'b0, count}, 32'd0);
        shift_en = 1'b1;
        repeat (n) tick();
        shift_en = 1'b0;
        chk({tag, "_valid_early"}, {31'b0, valid}, 32'd0);
        tick();
        chk({tag, "_valid"}, {31'b0, valid}, 32'd1);
        chk({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        load     = 1'b0;
        shift_en = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) tick();
        chk("rst_quotient", {6'b0, quotient}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_count", {27'b0, count}, 32'd0);
        rst_n = 1'b1;

        // Shift enable while idle must be ignored.
        shift_en = 1'b1;
        repeat (3) tick();
        shift_en = 1'b0;
        chk("idle_count", {27'b0, count}, 32'd0);
        tick();
        chk("idle_valid", {31'b0, valid}, 32'd0);

        // 1.0 / 1.0, with load and shift_en overlapping on the load edge.
        run_div("d1", 24'h800000, 24'h800000, 23, 1'b1);
        chk("d1_quotient", {6'b0, quotient}, 32'h400000);
        chk("d1_sticky", {31'b0, sticky}, 32'd0);
        chk("d1_count", {27'b0, count}, 32'd23);
        chk("d1_dz", {31'b0, dz}, 32'd0);
        tick();
        chk("d1_valid_pulse", {31'b0, valid}, 32'd0);
        chk("d1_quotient_hold", {6'b0, quotient}, 32'h400000);
        shift_en = 1'b1;
        tick();
        shift_en = 1'b0;
        chk("d1_count_hold", {27'b0, count}, 32'd23);

        // 1.5 / 1.0
        run_div("d2", 24'hC00000, 24'h800000, 23, 1'b0);
        chk("d2_quotient", {6'b0, quotient}, 32'h600000);
        chk("d2_sticky", {31'b0, sticky}, 32'd0);

        // 1.0 / 1.5 leaves a remainder.
        run_div("d3", 24'h800000, 24'hC00000, 23, 1'b0);
        chk("d3_quotient", {6'b0, quotient}, 32'h2AAAAA);
        chk("d3_sticky", {31'b0, sticky}, {31'b0, STICKY_ON});
        chk("d3_ovf", {31'b0, ovf}, 32'd0);

        // Divide by zero.
        run_div("d4", 24'h900000, 24'h000000, 23, 1'b0);
        chk("d4_dz", {31'b0, dz}, 32'd1);
        chk("d4_quotient", {6'b0, quotient}, 32'h7FFFFF);
        tick();
        chk("d4_dz_hold", {31'b0, dz}, 32'd1);

        // Asynchronous reset in the middle of a division.
        dividend = 24'hC00000;
        divisor  = 24'h800000;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        shift_en = 1'b1;
        repeat (10) tick();
        rst_n = 1'b0;
        #2;
        chk("ar_quotient", {6'b0, quotient}, 32'd0);
        chk("ar_count", {27'b0, count}, 32'd0);
        chk("ar_busy", {31'b0, busy}, 32'd0);
        chk("ar_dz", {31'b0, dz}, 32'd0);
        chk("ar_sticky", {31'b0, sticky}, 32'd0);
        #4;
        rst_n = 1'b1;
        repeat (3) tick();
        shift_en = 1'b0;
        chk("ar_count_idle", {27'b0, count}, 32'd0);
        tick();
        chk("ar_no_valid", {31'b0, valid}, 32'd0);
        tick();
        chk("ar_no_valid2", {31'b0, valid}, 32'd0);

        // 30 shifts overruns the 26-bit quotient register.
        run_div("d5", 24'h800000, 24'h000000, 30, 1'b0);
        chk("d5_ovf", {31'b0, ovf}, 32'd1);
        chk("d5_count", {27'b0, count}, 32'd30);
        chk("d5_quotient", {6'b0, quotient}, 32'h3FFFFFF);

        // A fresh load clears the overflow and divide-by-zero flags.
        dividend = 24'h800000;
        divisor  = 24'h800000;
        load     = 1'b1;
        tick();
        load = 1'b0;
        chk("ld_ovf_clear", {31'b0, ovf}, 32'd0);
        chk("ld_dz_clear", {31'b0, dz}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mant_div_datapath.md
MANT_DIV_DATAPATH -- requirements
Module: mant_div_datapath

Interface
REQ-001 Parameter MANT_W, default 24, mantissa width including hidden bit.
REQ-002 Parameter Q_W, default 26, quotient register width.
REQ-003 in_Clk  input  1  single clock; all state updates on rising edge.
REQ-004 in_Rst_N  input  1  asynchronous active-low reset.
REQ-005 in_load  input  1  load pulse from divider control FSM; captures operands.
REQ-006 in_shift_en  input  1  one quotient bit per cycle while high.
REQ-007 in_dividend  input  MANT_W  dividend mantissa, hidden bit at MSB.
REQ-008 in_divisor  input  MANT_W  divisor mantissa, hidden bit at MSB.
REQ-009 out_quotient  output  Q_W  quotient bits, LSB-justified, newest bit at bit 0.
REQ-010 out_sticky  output  1  remainder non-zero after final shift.
REQ-011 out_valid  output  1  one-cycle pulse: result stable.
REQ-012 out_busy  output  1  high from load capture until result valid.
REQ-013 out_count  output  5  number of shift cycles since last load, saturating at 31.
REQ-014 out_dz  output  1  divisor was zero at load.
REQ-015 out_ovf  output  1  shift count exceeded Q_W; sticky until next load.

Function
REQ-016 Internal registers: rem (MANT_W+1 bits), div (MANT_W bits), q (Q_W bits), cnt (5 bits), prev_shift (1 bit).
REQ-017 Load (in_load=1): rem<={0,in_dividend}, div<=in_divisor, q<=0, cnt<=0, out_dz<=(in_divisor==0), out_ovf<=0, out_busy<=1, out_valid<=0.
REQ-018 Shift cycle (in_shift_en=1, in_load=0): trial=rem-{0,div}; trial non-negative -> rem<=trial<<1, q<={q[Q_W-2:0],1}; else rem<=rem<<1, q<={q[Q_W-2:0],0}.
REQ-019 Shift cycle: cnt<=cnt+1, saturating at 31; cnt reaching Q_W+1 sets out_ovf.
REQ-020 in_load and in_shift_en both high: load wins, no shift performed.
REQ-021 out_valid pulses exactly one cycle after the cycle where prev_shift=1 and in_shift_en=0, only while out_busy=1; same edge clears out_busy.
REQ-022 Divide-by-zero: shifts still run (every trial succeeds), q all ones in shifted bits; out_dz stays high until next load.
REQ-023 out_quotient, out_sticky, out_count hold value after out_valid until next load.
REQ-024 in_shift_en while out_busy=0: ignored, no register change, no out_valid.
REQ-025 out_quotient drives q; out_count drives cnt; no combinational path from inputs to outputs.
REQ-026 Latency: load edge + N shift cycles + 1 cycle -> out_valid; control FSM delivers N=23 for 24-bit mantissas.

Reset
REQ-027 in_Rst_N low: rem, div, q, cnt, prev_shift = 0; out_valid, out_busy, out_dz, out_ovf, out_sticky = 0, regardless of clock.
REQ-028 Reset mid-operation aborts division; no out_valid produced for the aborted operation.
REQ-029 Reset release: idle until next in_load.

Configuration
REQ-030 Macro MANT_DIV_STICKY_EN defined: out_sticky registered as (rem!=0) on the out_valid edge, held until next load.
REQ-031 Macro MANT_DIV_STICKY_EN undefined: out_sticky tied 0, no remainder-compare logic built.

Verification
REQ-032 dividend 0x800000, divisor 0x800000, load + 23 shifts -> out_valid one cycle after shift_en falls, out_quotient 0x400000, out_sticky 0, out_count 23.
REQ-033 dividend 0xC00000, divisor 0x800000, 23 shifts -> out_quotient 0x600000, out_sticky 0.
REQ-034 dividend 0x800000, divisor 0xC00000, 23 shifts -> out_quotient 0x2AAAAA, out_sticky 1 (0 with macro undefined).
REQ-035 divisor 0x000000, 23 shifts -> out_dz 1, out_quotient 0x7FFFFF, out_valid pulses.
REQ-036 in_Rst_N low at shift 10 -> all outputs 0 immediately, no out_valid after release; 30 shifts after new load -> out_ovf 1, out_count 30.
